// File: rtl/softmax_buf2dat.sv
// softmax_buf2dat: drains the softmax pixel buffer in fill order
// (h / w-burst / ch-group / pixel) and presents one Tout-wide beat per read
// to the MCIF write path through a small skid FIFO, returning one credit per
// accepted beat.
module softmax_buf2dat #(
  parameter int DAT_DW     = 16,
  parameter int TOUT       = 32,
  parameter int BURST_LEN  = 16,
  parameter int LOG2_BURST = 4,
  parameter int LOG2_H     = 12,
  parameter int LOG2_W     = 12,
  parameter int LOG2_CHG   = 8,
  parameter int PIX_AW     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [LOG2_CHG-1:0]      CH_in_div_Tout,
  input  logic [LOG2_H-1:0]        h_in,
  input  logic [LOG2_W-1:0]        w_in,
  input  logic                     burst_done,
  output logic                     buf_rd_en,
  output logic [PIX_AW-1:0]        buf_pixel_addr,
  output logic [LOG2_CHG-1:0]      buf_ch_addr,
  input  logic [DAT_DW*TOUT-1:0]   buf_rd_dat,
  output logic                     wr_req_vld,
  input  logic                     wr_req_rdy,
  output logic [DAT_DW*TOUT-1:0]   wr_req_pd,
  output logic                     credit_vld,
  output logic                     busy,
  output logic                     done
);

  localparam int BEAT_W = DAT_DW * TOUT;
  localparam int WB_W   = LOG2_W - LOG2_BURST;
  localparam int FAW    = $clog2(FIFO_DEPTH);
  localparam int FCW    = FAW + 1;
  localparam logic [FCW:0]          DEPTH_LIM = (FCW+1)'(FIFO_DEPTH);
  localparam logic [LOG2_BURST-1:0] FULL_M1   = LOG2_BURST'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Latched frame configuration
  logic [LOG2_CHG-1:0]   cfg_chg;
  logic [LOG2_H-1:0]     cfg_h;
  logic [LOG2_W-1:0]     cfg_w;

  // Loop counters, innermost first: w_cnt -> ch_cnt -> wb_cnt -> h_cnt
  logic [LOG2_BURST-1:0] w_cnt;
  logic [LOG2_CHG-1:0]   ch_cnt;
  logic [WB_W-1:0]       wb_cnt;
  logic [LOG2_H-1:0]     h_cnt;
  logic [PIX_AW-1:0]     row_base;   // h_cnt * cfg_w, kept as a running sum

  logic [4:0]            rdy_cnt;
  logic                  in_flight;  // a read issued last cycle, data arriving now

  logic [BEAT_W-1:0]     fifo_mem [FIFO_DEPTH];
  logic [FAW-1:0]        wr_ptr, rd_ptr;
  logic [FCW-1:0]        fifo_cnt;

  logic [LOG2_W-1:0]     wb_last_idx;
  logic [LOG2_BURST-1:0] tail, len_m1;
  logic                  wb_is_last, w_last, ch_last, h_last;
  logic                  burst_last, frame_last;
  logic                  start_ok, rd_fire, rdy_dec, push, pop, final_pop;

  // Loop-bound decode; the last w-burst of a row may be a partial burst
  assign wb_last_idx = (cfg_w - 1'b1) >> LOG2_BURST;
  assign tail        = cfg_w[LOG2_BURST-1:0];
  assign wb_is_last  = ({{LOG2_BURST{1'b0}}, wb_cnt} == wb_last_idx);
  assign len_m1      = (wb_is_last && (tail != '0)) ? tail - 1'b1 : FULL_M1;
  assign w_last      = (w_cnt == len_m1);
  assign ch_last     = (ch_cnt == cfg_chg - 1'b1);
  assign h_last      = (h_cnt == cfg_h - 1'b1);
  assign burst_last  = w_last && ch_last;
  assign frame_last  = burst_last && wb_is_last && h_last;

  // Read issue: a ready burst exists and the FIFO has room for everything in flight
  assign start_ok  = start && (state == S_IDLE);
  assign rd_fire   = (state == S_RUN) && (rdy_cnt != '0) &&
                     (({1'b0, fifo_cnt} + {{FCW{1'b0}}, in_flight}) < DEPTH_LIM);
  assign rdy_dec   = rd_fire && burst_last;

  assign push      = in_flight;
  assign pop       = wr_req_vld && wr_req_rdy;
  assign final_pop = (state == S_DRAIN) && pop && (fifo_cnt == FCW'(1)) && !in_flight;

  assign buf_rd_en      = rd_fire;
  assign buf_ch_addr    = ch_cnt;
  assign buf_pixel_addr = row_base + (PIX_AW'(wb_cnt) << LOG2_BURST) + PIX_AW'(w_cnt);
  assign wr_req_vld     = (fifo_cnt != '0);
  assign wr_req_pd      = wr_req_vld ? fifo_mem[rd_ptr] : '0;
  assign busy           = (state != S_IDLE);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  // NOTE: the default assignment first guarantees no latch is inferred on any path.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start_ok)              state_nxt = S_RUN;
      S_RUN:   if (rd_fire && frame_last) state_nxt = S_DRAIN;
      S_DRAIN: if (final_pop)             state_nxt = S_IDLE;
      default:                            state_nxt = S_IDLE;
    endcase
  end

  // Config latch and nested address counters, advancing once per read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_chg  <= '0;
      cfg_h    <= '0;
      cfg_w    <= '0;
      w_cnt    <= '0;
      ch_cnt   <= '0;
      wb_cnt   <= '0;
      h_cnt    <= '0;
      row_base <= '0;
    end else if (start_ok) begin
      cfg_chg  <= CH_in_div_Tout;
      cfg_h    <= h_in;
      cfg_w    <= w_in;
      w_cnt    <= '0;
      ch_cnt   <= '0;
      wb_cnt   <= '0;
      h_cnt    <= '0;
      row_base <= '0;
    end else if (rd_fire) begin
      if (!w_last) begin
        w_cnt <= w_cnt + 1'b1;
      end else begin
        w_cnt <= '0;
        if (!ch_last) begin
          ch_cnt <= ch_cnt + 1'b1;
        end else begin
          ch_cnt <= '0;
          if (!wb_is_last) begin
            wb_cnt <= wb_cnt + 1'b1;
          end else begin
            wb_cnt <= '0;
            if (!h_last) begin
              h_cnt    <= h_cnt + 1'b1;
              row_base <= row_base + PIX_AW'(cfg_w);
            end else begin
              h_cnt    <= '0;
              row_base <= '0;
            end
          end
        end
      end
    end
  end

  // Ready-burst count: +1 per burst_done, -1 per burst's final read, saturating at 31
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_cnt <= '0;
    end else if (burst_done && !rdy_dec) begin
      if (rdy_cnt != 5'd31) rdy_cnt <= rdy_cnt + 1'b1;
    end else if (!burst_done && rdy_dec) begin
      rdy_cnt <= rdy_cnt - 1'b1;
    end
  end

  // Skid FIFO storage
  // NOTE: the data array is deliberately not reset; validity is tracked by fifo_cnt alone.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= buf_rd_dat;
  end

  // Skid FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Read-latency tracker, credit return and end-of-frame pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight  <= 1'b0;
      credit_vld <= 1'b0;
      done       <= 1'b0;
    end else begin
      in_flight  <= rd_fire;
      credit_vld <= pop;
      done       <= final_pop;
    end
  end

endmodule

// File: tb/tb_softmax_buf2dat.sv
// Self-checking bench for softmax_buf2dat. The buffer is modelled as a pure
// function of (pixel, ch group, per-test salt); the expected read order is
// built from the frame loop nest with plain arithmetic.
module tb_softmax_buf2dat;

  localparam int DAT_DW     = 16;
  localparam int TOUT       = 32;
  localparam int BURST_LEN  = 16;
  localparam int LOG2_BURST = 4;
  localparam int LOG2_H     = 12;
  localparam int LOG2_W     = 12;
  localparam int LOG2_CHG   = 8;
  localparam int PIX_AW     = 12;
  localparam int FIFO_DEPTH = 4;
  localparam int BEAT_W     = DAT_DW * TOUT;
  localparam int OUT_W      = BEAT_W + PIX_AW + LOG2_CHG + 5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [LOG2_CHG-1:0]  chg_in = '0;
  logic [LOG2_H-1:0]    h_in = '0;
  logic [LOG2_W-1:0]    w_in = '0;
  logic                 burst_done = 1'b0;
  logic                 buf_rd_en;
  logic [PIX_AW-1:0]    buf_pixel_addr;
  logic [LOG2_CHG-1:0]  buf_ch_addr;
  logic [BEAT_W-1:0]    buf_rd_dat = '0;
  logic                 wr_req_vld;
  logic                 wr_req_rdy = 1'b0;
  logic [BEAT_W-1:0]    wr_req_pd;
  logic                 credit_vld;
  logic                 busy;
  logic                 done;

  softmax_buf2dat #(
    .DAT_DW(DAT_DW), .TOUT(TOUT), .BURST_LEN(BURST_LEN), .LOG2_BURST(LOG2_BURST),
    .LOG2_H(LOG2_H), .LOG2_W(LOG2_W), .LOG2_CHG(LOG2_CHG), .PIX_AW(PIX_AW),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .CH_in_div_Tout(chg_in),
    .h_in(h_in), .w_in(w_in), .burst_done(burst_done),
    .buf_rd_en(buf_rd_en), .buf_pixel_addr(buf_pixel_addr), .buf_ch_addr(buf_ch_addr),
    .buf_rd_dat(buf_rd_dat), .wr_req_vld(wr_req_vld), .wr_req_rdy(wr_req_rdy),
    .wr_req_pd(wr_req_pd), .credit_vld(credit_vld), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int rdy_mode = 0;            // 0: always ready, 1: toggle, 2: random
  logic [7:0] salt = 8'h00;

  // Expected read order and observed traffic
  int                  exp_pix[$];
  int                  exp_ch[$];
  logic [PIX_AW-1:0]   rd_pix[$];
  logic [LOG2_CHG-1:0] rd_ch[$];
  logic [BEAT_W-1:0]   beats[$];
  int cyc = 0, first_rd = -1, first_vld = -1, last_acc = -1, done_cyc = -1;
  int outstanding = 0, max_out = 0, stall_viol = 0, credit_cnt = 0, done_cnt = 0;
  int done_busy_viol = 0;
  logic               stalled_prev = 1'b0;
  logic [BEAT_W-1:0]  prev_pd = '0;

  // Buffer content model: every word tagged with its address and the salt
  function automatic logic [BEAT_W-1:0] beat_of(input int pix, input int ch, input logic [7:0] s);
    logic [BEAT_W-1:0] b;
    for (int i = 0; i < BEAT_W / 32; i++) b[i*32 +: 32] = {12'(pix), 8'(ch), s, 4'(i)};
    return b;
  endfunction

  function automatic logic [OUT_W-1:0] all_outputs();
    return {buf_rd_en, wr_req_vld, credit_vld, busy, done, buf_pixel_addr, buf_ch_addr, wr_req_pd};
  endfunction

  // Buffer responder: data valid exactly one cycle after buf_rd_en, junk otherwise
  initial begin
    logic r;
    logic [PIX_AW-1:0] p;
    logic [LOG2_CHG-1:0] c;
    logic [BEAT_W-1:0] j;
    forever begin
      @(negedge clk);
      r = buf_rd_en;
      p = buf_pixel_addr;
      c = buf_ch_addr;
      @(posedge clk);
      #1;
      if (r) begin
        buf_rd_dat = beat_of(int'(p), int'(c), salt);
      end else begin
        for (int i = 0; i < BEAT_W / 32; i++) j[i*32 +: 32] = $urandom();
        buf_rd_dat = j;
      end
    end
  end

  // MCIF ready pattern
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       wr_req_rdy = 1'b1;
      1:       wr_req_rdy = ~wr_req_rdy;
      default: wr_req_rdy = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Traffic monitor, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    cyc++;
    if (buf_rd_en) begin
      rd_pix.push_back(buf_pixel_addr);
      rd_ch.push_back(buf_ch_addr);
      if (first_rd < 0) first_rd = cyc;
      outstanding++;
    end
    if (wr_req_vld && first_vld < 0) first_vld = cyc;
    if (stalled_prev && (!wr_req_vld || wr_req_pd !== prev_pd)) stall_viol++;
    if (wr_req_vld && wr_req_rdy) begin
      beats.push_back(wr_req_pd);
      outstanding--;
      last_acc = cyc;
    end
    if (outstanding > max_out) max_out = outstanding;
    stalled_prev = wr_req_vld && !wr_req_rdy;
    prev_pd      = wr_req_pd;
    if (credit_vld) credit_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (busy) done_busy_viol++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rd_pix.delete(); rd_ch.delete(); beats.delete();
    first_rd = -1; first_vld = -1; last_acc = -1; done_cyc = -1;
    outstanding = 0; max_out = 0; stall_viol = 0; credit_cnt = 0; done_cnt = 0;
    done_busy_viol = 0; stalled_prev = 1'b0;
  endtask

  task automatic do_start(input int h, input int w, input int c);
    h_in = LOG2_H'(h); w_in = LOG2_W'(w); chg_in = LOG2_CHG'(c);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_burst(input int n);
    repeat (n) begin
      burst_done = 1'b1;
      step();
    end
    burst_done = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    repeat (3) step();
  endtask

  // Reference loop nest: h -> w-burst -> ch group -> pixel within burst
  task automatic build_exp(input int h, input int w, input int chg);
    exp_pix.delete(); exp_ch.delete();
    for (int r = 0; r < h; r++)
      for (int b = 0; b * BURST_LEN < w; b++) begin
        int len = (w - b * BURST_LEN < BURST_LEN) ? w - b * BURST_LEN : BURST_LEN;
        for (int c = 0; c < chg; c++)
          for (int x = 0; x < len; x++) begin
            exp_pix.push_back(r * w + b * BURST_LEN + x);
            exp_ch.push_back(c);
          end
      end
  endtask

  // Mismatch tallies of observed reads/beats against the expected order
  task automatic score(output int aerr, output int derr);
    aerr = (rd_pix.size() != exp_pix.size()) ? 1 : 0;
    derr = (beats.size() != exp_pix.size()) ? 1 : 0;
    for (int i = 0; i < rd_pix.size() && i < exp_pix.size(); i++)
      if (rd_pix[i] !== PIX_AW'(exp_pix[i]) || rd_ch[i] !== LOG2_CHG'(exp_ch[i])) aerr++;
    for (int i = 0; i < beats.size() && i < exp_pix.size(); i++)
      if (beats[i] !== beat_of(exp_pix[i], exp_ch[i], salt)) derr++;
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_cmp++; if (all_outputs() !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", all_outputs()); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (all_outputs() !== '0) begin n_fail++; $display("FAIL reset_release_outputs: got %h want 0", all_outputs()); end
  endtask

  task automatic test_single_burst();
    int aerr, derr;
    clear_mon(); salt = 8'($urandom()); rdy_mode = 0;
    build_exp(1, 16, 1);
    pulse_burst(1);                      // counted while still idle
    do_start(1, 16, 1);
    wait_done(2000);
    score(aerr, derr);
    n_cmp++; if (aerr !== 0) begin n_fail++; $display("FAIL t1_addr: %0d bad reads, want 0", aerr); end
    n_cmp++; if (derr !== 0) begin n_fail++; $display("FAIL t1_data: %0d bad beats, want 0", derr); end
    n_cmp++; if (beats.size() !== 16) begin n_fail++; $display("FAIL t1_beats: got %0d want 16", beats.size()); end
    n_cmp++; if (first_vld - first_rd !== 2) begin n_fail++; $display("FAIL t1_latency: got %0d want 2", first_vld - first_rd); end
    n_cmp++; if (credit_cnt !== 16) begin n_fail++; $display("FAIL t1_credits: got %0d want 16", credit_cnt); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL t1_done: got %0d want 1", done_cnt); end
    n_cmp++; if (done_cyc !== last_acc + 1) begin n_fail++; $display("FAIL t1_done_time: got %0d want %0d", done_cyc, last_acc + 1); end
    n_cmp++; if (done_busy_viol !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy: viol %0d busy %0b want 0 0", done_busy_viol, busy); end
  endtask

  task automatic test_multi_row();
    int aerr, derr;
    clear_mon(); salt = 8'($urandom()); rdy_mode = 0;
    build_exp(2, 20, 2);
    do_start(2, 20, 2);
    pulse_burst(4);
    wait_done(3000);
    score(aerr, derr);
    n_cmp++; if (aerr !== 0) begin n_fail++; $display("FAIL t2_addr: %0d bad reads, want 0", aerr); end
    n_cmp++; if (derr !== 0) begin n_fail++; $display("FAIL t2_data: %0d bad beats, want 0", derr); end
    n_cmp++; if (beats.size() !== 80) begin n_fail++; $display("FAIL t2_beats: got %0d want 80", beats.size()); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL t2_done: got %0d want 1", done_cnt); end
    // Every ready burst consumed: a fresh frame must not read until a new burst_done
    clear_mon();
    do_start(1, 16, 1);
    repeat (40) step();
    n_cmp++; if (rd_pix.size() !== 0) begin n_fail++; $display("FAIL t2_rdy_zero: got %0d reads want 0", rd_pix.size()); end
    pulse_burst(1);
    wait_done(2000);
    n_cmp++; if (rd_pix.size() !== 16 || done_cnt !== 1) begin n_fail++; $display("FAIL t2_refill: reads %0d done %0d want 16 1", rd_pix.size(), done_cnt); end
  endtask

  task automatic test_stall();
    int aerr, derr;
    clear_mon(); salt = 8'($urandom()); rdy_mode = 1;
    build_exp(1, 16, 1);
    pulse_burst(1);
    do_start(1, 16, 1);
    wait_done(2000);
    score(aerr, derr);
    n_cmp++; if (stall_viol !== 0) begin n_fail++; $display("FAIL t3_stable: %0d payload changes under stall, want 0", stall_viol); end
    n_cmp++; if (max_out > FIFO_DEPTH) begin n_fail++; $display("FAIL t3_occupancy: got %0d want <= %0d", max_out, FIFO_DEPTH); end
    n_cmp++; if (derr !== 0 || beats.size() !== 16) begin n_fail++; $display("FAIL t3_data: bad %0d beats %0d want 0 16", derr, beats.size()); end
    n_cmp++; if (credit_cnt !== 16) begin n_fail++; $display("FAIL t3_credits: got %0d want 16", credit_cnt); end
  endtask

  task automatic test_withhold();
    int aerr, derr, n;
    bit hit;
    clear_mon(); salt = 8'($urandom()); rdy_mode = 0;
    build_exp(1, 64, 2);
    pulse_burst(1);
    do_start(1, 64, 2);
    repeat (100) step();
    n_cmp++; if (rd_pix.size() !== 32) begin n_fail++; $display("FAIL t4_stop1: got %0d reads want 32", rd_pix.size()); end
    pulse_burst(1);
    // Land a burst_done on the cycle the final read of the second burst issues
    hit = 1'b0; n = 0;
    while (!hit && n < 300) begin
      if (buf_rd_en && buf_pixel_addr == PIX_AW'(31) && buf_ch_addr == LOG2_CHG'(1)) begin
        hit = 1'b1;
        burst_done = 1'b1;
      end
      step();
      burst_done = 1'b0;
      n++;
    end
    n_cmp++; if (hit !== 1'b1) begin n_fail++; $display("FAIL t4_align: final read of burst 1 seen %0b want 1", hit); end
    repeat (100) step();
    n_cmp++; if (rd_pix.size() !== 96) begin n_fail++; $display("FAIL t4_coincident: got %0d reads want 96", rd_pix.size()); end
    pulse_burst(1);
    wait_done(2000);
    score(aerr, derr);
    n_cmp++; if (aerr !== 0 || derr !== 0) begin n_fail++; $display("FAIL t4_order: addr %0d data %0d want 0 0", aerr, derr); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL t4_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    int aerr, derr;
    clear_mon(); salt = 8'($urandom()); rdy_mode = 2;
    do_start(2, 20, 2);
    pulse_burst(4);
    repeat (20) step();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (all_outputs() !== '0) begin n_fail++; $display("FAIL t5_reset_outputs: got %h want 0", all_outputs()); end
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();
    n_cmp++; if (done_cnt !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL t5_abort: done %0d busy %0b want 0 0", done_cnt, busy); end
    clear_mon(); salt = 8'($urandom());
    build_exp(1, 24, 3);
    do_start(1, 24, 3);
    pulse_burst(2);
    wait_done(3000);
    score(aerr, derr);
    n_cmp++; if (aerr !== 0 || derr !== 0) begin n_fail++; $display("FAIL t5_rerun: addr %0d data %0d want 0 0", aerr, derr); end
    n_cmp++; if (done_cnt !== 1 || credit_cnt !== 72) begin n_fail++; $display("FAIL t5_rerun_done: done %0d credits %0d want 1 72", done_cnt, credit_cnt); end
  endtask

  task automatic test_start_ignored();
    int aerr, derr;
    clear_mon(); salt = 8'($urandom()); rdy_mode = 1;
    build_exp(1, 16, 1);
    do_start(1, 16, 1);
    pulse_burst(1);
    repeat (4) step();
    do_start(3, 40, 4);
    wait_done(2000);
    score(aerr, derr);
    n_cmp++; if (aerr !== 0 || beats.size() !== 16) begin n_fail++; $display("FAIL t6_ignored: addr %0d beats %0d want 0 16", aerr, beats.size()); end
    n_cmp++; if (done_cnt !== 1 || derr !== 0) begin n_fail++; $display("FAIL t6_done: done %0d data %0d want 1 0", done_cnt, derr); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      int h, w, c, rem, n, aerr, derr;
      h = $urandom_range(1, 3); w = $urandom_range(1, 40); c = $urandom_range(1, 3);
      clear_mon(); salt = 8'($urandom()); rdy_mode = 2;
      build_exp(h, w, c);
      rem = h * ((w + BURST_LEN - 1) / BURST_LEN);
      do_start(h, w, c);
      n = 0;
      while (done_cnt == 0 && n < 6000) begin
        burst_done = (rem > 0) && ($urandom_range(0, 5) == 0);
        if (burst_done) rem--;
        step();
        n++;
      end
      burst_done = 1'b0;
      repeat (3) step();
      score(aerr, derr);
      n_cmp++; if (aerr !== 0 || derr !== 0) begin n_fail++; $display("FAIL rnd%0d_order h%0d w%0d c%0d: addr %0d data %0d want 0 0", f, h, w, c, aerr, derr); end
      n_cmp++; if (credit_cnt !== h * w * c || done_cnt !== 1) begin n_fail++; $display("FAIL rnd%0d_credits: credits %0d done %0d want %0d 1", f, credit_cnt, done_cnt, h * w * c); end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_multi_row();
    test_stall();
    test_withhold();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
